bist_misr_checker: RTL

- Response-side BIST block for the Booth multiplier: the receiving end of the LFSR pattern generator.
- Drives `shift` to the 8-bit pattern LFSR while a test runs.
- Compacts each 16-bit multiplier product into a 16-bit MISR (multiple-input signature register), counts NPAT responses, then compares the final signature against a golden constant and reports pass/fail.

---
 rtl/bist_misr_checker.sv | 99 +++++++++
 1 files changed

// File: rtl/bist_misr_checker.sv
// Response-side BIST checker: compacts multiplier products into a 16-bit MISR
// and compares the final signature against GOLDEN after NPAT responses.
module bist_misr_checker #(
    parameter int unsigned           WIDTH  = 16,
    parameter int unsigned           NPAT   = 255,
    parameter logic [WIDTH-1:0]      GOLDEN = '0
) (
    input  logic             clk,
    input  logic             seed_b,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] sig
);

    localparam int unsigned      CW   = $clog2(NPAT + 1);
    localparam logic [CW-1:0]    LAST = CW'(NPAT - 1);
    // Feedback mask for x^16+x^14+x^13+x^11+1: bits 0, 11, 13, 14.
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(16'h6801);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d, misr_next;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    always_comb begin
        misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? TAPS : '0) ^ resp;
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        done_d  = done_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sig_d   = '0;
                    count_d = '0;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    sig_d   = misr_next;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) state_d = CHECK;
                end
            end
            CHECK: begin
                pass_d  = (sig_q == GOLDEN);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // A restart response arriving with start is dropped, not compacted.
                if (start) begin
                    state_d = RUN;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    sig_d   = '0;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge seed_b) begin
        if (!seed_b) begin
            state_q <= IDLE;
            sig_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign shift = (state_q == RUN);
    assign busy  = (state_q == RUN) || (state_q == CHECK);
    assign done  = done_q;
    assign pass  = pass_q;
    assign sig   = sig_q;

endmodule
